// File: rtl/npc_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the NPC core with halt status and perf counters.
// Optional: define NPC_MEM_TIMEOUT_EN to halt (code 3) after TIMEOUT wait cycles in IF or MEM.
module npc_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_rvalid,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_rvalid,
  input  logic             dec_rf_wen,
  input  logic             dec_dram_en,
  input  logic             dec_dram_wen,
  input  logic             dec_ebreak,
  input  logic             dec_illegal,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StMem  = 3'd4,
    StWb   = 3'd5,
    StHalt = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       halt_code_q, halt_code_d;
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             timed_out;
  logic             counting;

`ifdef NPC_MEM_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;

  // wait_q counts wait cycles already spent; this cycle is the TIMEOUT-th one
  assign timed_out = (wait_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    wait_d = '0;
    if ((state_q == StIf || state_q == StMem) && state_d == state_q) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    halt_code_d = halt_code_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      StIdle: state_d = StIf;
      StIf: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          ir_we   = 1'b1;
          state_d = StId;
        end else if (timed_out) begin
          state_d     = StHalt;
          halt_code_d = 2'd3;
        end
      end
      StId: begin
        if (dec_ebreak) begin
          state_d     = StHalt;
          halt_code_d = 2'd1;
        end else if (dec_illegal) begin
          state_d     = StHalt;
          halt_code_d = 2'd2;
        end else begin
          state_d = StEx;
        end
      end
      StEx: state_d = dec_dram_en ? StMem : StWb;
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = dec_dram_wen;
        if (dmem_rvalid) begin
          state_d = StWb;
        end else if (timed_out) begin
          state_d     = StHalt;
          halt_code_d = 2'd3;
        end
      end
      StWb: begin
        pc_we   = 1'b1;
        rf_we   = dec_rf_wen;
        state_d = StIf;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  assign counting = (state_q == StIf) || (state_q == StId) || (state_q == StEx) ||
                    (state_q == StMem) || (state_q == StWb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      halt_code_q <= 2'd0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      halt_code_q <= halt_code_d;
      if (counting) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (state_q == StWb) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign state       = state_q;
  assign halt        = (state_q == StHalt);
  assign halt_code   = halt_code_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: directed per-cycle expectations queued by stimulus,
// popped and compared by a monitor on the falling clock edge.
module tb_npc_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  stb;  // {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}
    logic        hlt;
    logic [1:0]  hc;
    logic [31:0] cyc;
    logic [31:0] ins;
  } obs_t;

  localparam logic [5:0] SNone = 6'b000000;
  localparam logic [5:0] SIfW  = 6'b100000;
  localparam logic [5:0] SIfR  = 6'b110000;
  localparam logic [5:0] SMemR = 6'b001000;
  localparam logic [5:0] SMemW = 6'b001100;
  localparam logic [5:0] SWb   = 6'b000010;
  localparam logic [5:0] SWbR  = 6'b000011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_rvalid, dmem_req, dmem_we, dmem_rvalid;
  logic        dec_rf_wen, dec_dram_en, dec_dram_wen, dec_ebreak, dec_illegal;
  logic        ir_we, pc_we, rf_we, halt;
  logic [2:0]  state;
  logic [1:0]  halt_code;
  logic [31:0] cycle_cnt, instret_cnt;

  obs_t        expq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ecyc = 0;
  int          eins = 0;

  always #5 clk = ~clk;

  npc_ctrl #(
`ifdef NPC_MEM_TIMEOUT_EN
    .TIMEOUT(4),
`endif
    .CNT_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_rvalid (imem_rvalid),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_rvalid (dmem_rvalid),
    .dec_rf_wen  (dec_rf_wen),
    .dec_dram_en (dec_dram_en),
    .dec_dram_wen(dec_dram_wen),
    .dec_ebreak  (dec_ebreak),
    .dec_illegal (dec_illegal),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_we       (rf_we),
    .state       (state),
    .halt        (halt),
    .halt_code   (halt_code),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  // Monitor: every cycle with a queued expectation is compared mid-cycle
  always @(negedge clk) begin
    obs_t a, e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      a.st  = state;
      a.stb = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we};
      a.hlt = halt;
      a.hc  = halt_code;
      a.cyc = cycle_cnt;
      a.ins = instret_cnt;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_obs t=%0t: state %0d want %0d, strobes %b want %b, halt %b want %b, code %0d want %0d, cycle_cnt %0d want %0d, instret %0d want %0d",
                 $time, a.st, e.st, a.stb, e.stb, a.hlt, e.hlt, a.hc, e.hc, a.cyc, e.cyc,
                 a.ins, e.ins);
      end
    end
  end

  task automatic dec(input logic rfw, input logic en, input logic wen, input logic eb,
                     input logic il);
    dec_rf_wen   = rfw;
    dec_dram_en  = en;
    dec_dram_wen = wen;
    dec_ebreak   = eb;
    dec_illegal  = il;
  endtask

  // Drive one cycle and queue what the DUT must show during it
  task automatic step(input logic r, input logic irv, input logic drv, input logic [2:0] st,
                      input logic [5:0] stb, input logic [1:0] hc);
    obs_t e;
    rst_n       = r;
    imem_rvalid = irv;
    dmem_rvalid = drv;
    if (!r) begin
      ecyc = 0;
      eins = 0;
    end
    e.st  = st;
    e.stb = stb;
    e.hlt = (st == 3'd6);
    e.hc  = hc;
    e.cyc = ecyc;
    e.ins = eins;
    expq.push_back(e);
    @(posedge clk);
    #1;
    if (r && st >= 3'd1 && st <= 3'd5) ecyc++;
    if (r && st == 3'd5) eins++;
  endtask

  initial begin
    imem_rvalid = 1'b0;
    dmem_rvalid = 1'b0;
    dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, SNone, 2'd0);

    // addi, zero-wait fetch; stray dmem_rvalid in EX must be ignored
    dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b1, 3'd3, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd5, SWbR, 2'd0);

    // load: one fetch wait, dmem_rvalid three cycles late
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'd1, SIfW, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd3, SNone, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd4, SMemR, 2'd0);
    step(1'b1, 1'b0, 1'b1, 3'd4, SMemR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd5, SWbR, 2'd0);

    // store; stray imem_rvalid in ID/EX must be ignored
    dec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd2, SNone, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd3, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd4, SMemW, 2'd0);
    step(1'b1, 1'b0, 1'b1, 3'd4, SMemW, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd5, SWb, 2'd0);

    // illegal: halts with code 2, no WB
    dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 3'd6, SNone, 2'd2);

    // reset out of HALT, then reset again mid-MEM of a load
    step(1'b0, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd3, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd4, SMemR, 2'd0);
    step(1'b0, 1'b0, 1'b1, 3'd0, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, SNone, 2'd0);

    // ebreak wins over illegal; HALT ignores fetch data and freezes counters
    dec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 3'd6, SNone, 2'd1);

    // fetch that never completes
    dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
`ifdef NPC_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 3'd1, SIfW, 2'd0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 3'd6, SNone, 2'd3);
    // rvalid on the TIMEOUT cycle itself completes the fetch
    step(1'b0, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd0, SNone, 2'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd1, SIfW, 2'd0);
    step(1'b1, 1'b1, 1'b0, 3'd1, SIfR, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd2, SNone, 2'd0);
    step(1'b1, 1'b0, 1'b0, 3'd3, SNone, 2'd0);
`else
    for (int i = 0; i < 110; i++) step(1'b1, 1'b0, 1'b0, 3'd1, SIfW, 2'd0);
`endif

    @(negedge clk);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, want 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
